// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the multicycle processor control unit: opcodes, IR
// field positions, FSM states, bank DataIn mux codes and decoded control flags.
package proc_ctrl_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int RX_MSB = 12;
  localparam int RX_LSB = 10;
  localparam int RY_MSB = 9;
  localparam int RY_LSB = 7;

  localparam logic [2:0] PC_REG = 3'd7;

  localparam logic [1:0] DSEL_OUT2 = 2'b00;
  localparam logic [1:0] DSEL_ALU  = 2'b01;
  localparam logic [1:0] DSEL_MEM  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_FAULT
  } state_t;

  // One-hot-ish behaviour flags for the EXEC state
  typedef struct packed {
    logic       nop;
    logic       mem;
    logic       store;
    logic       alu;
    logic       sub;
    logic       cond;
    logic       imm;
    logic       write;
    logic [1:0] data_sel;
  } ctrl_t;

endpackage

// File: rtl/proc_ir_decode.sv
// Combinational instruction decode: splits IR into Rx/Ry and the per-opcode
// control flags consumed by the EXEC state of proc_control_fsm.
module proc_ir_decode
  import proc_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rx,
  output logic [2:0]  ry,
  output ctrl_t       ctrl
);

  logic [2:0] op;
  logic       unused_ir_low;

  assign op            = ir[OP_MSB:OP_LSB];
  assign rx            = ir[RX_MSB:RX_LSB];
  assign ry            = ir[RY_MSB:RY_LSB];
  assign unused_ir_low = ^ir[RY_LSB-1:0];

  always_comb begin
    ctrl          = '0;
    ctrl.data_sel = DSEL_OUT2;
    case (op)
      OP_MV:   ctrl.write = 1'b1;
      OP_MVI: begin
        ctrl.mem      = 1'b1;
        ctrl.imm      = 1'b1;
        ctrl.write    = 1'b1;
        ctrl.data_sel = DSEL_MEM;
      end
      OP_ADD: begin
        ctrl.alu      = 1'b1;
        ctrl.write    = 1'b1;
        ctrl.data_sel = DSEL_ALU;
      end
      OP_SUB: begin
        ctrl.alu      = 1'b1;
        ctrl.sub      = 1'b1;
        ctrl.write    = 1'b1;
        ctrl.data_sel = DSEL_ALU;
      end
      OP_LD: begin
        ctrl.mem      = 1'b1;
        ctrl.write    = 1'b1;
        ctrl.data_sel = DSEL_MEM;
      end
      OP_ST: begin
        ctrl.mem   = 1'b1;
        ctrl.store = 1'b1;
      end
      OP_MVNZ: begin
        ctrl.cond  = 1'b1;
        ctrl.write = 1'b1;
      end
      default: ctrl.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multicycle control FSM for the 16-bit processor (fetch/decode/exec/done).
// Define PROC_CTRL_TIMEOUT_EN to add the memory-ack timeout and sticky FAULT state.
module proc_control_fsm
  import proc_ctrl_pkg::*;
`ifdef PROC_CTRL_TIMEOUT_EN
#(
  parameter int MEM_TIMEOUT = 15
)
`endif
(
  input  logic        p_Clock,
  input  logic        p_Resetn,
  input  logic        p_Run,
  input  logic [15:0] p_MemData,
  input  logic        p_MemAck,
  input  logic        p_AluZero,
  output logic        p_MemReq,
  output logic        p_MemWe,
  output logic [2:0]  p_ReadAddr1,
  output logic [2:0]  p_ReadAddr2,
  output logic [2:0]  p_WriteAddr,
  output logic        p_EnableWrite,
  output logic        p_IncPC,
  output logic        p_AluOp,
  output logic [1:0]  p_DataSel,
  output logic        p_Done,
  output logic        p_Fault
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        nz_q, nz_d;
  logic        inc_pc;
  logic [2:0]  rx, ry;
  ctrl_t       ctrl;

`ifdef PROC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  proc_ir_decode u_decode (
    .ir   (ir_q),
    .rx   (rx),
    .ry   (ry),
    .ctrl (ctrl)
  );

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    nz_d          = nz_q;
    inc_pc        = 1'b0;
    p_MemReq      = 1'b0;
    p_MemWe       = 1'b0;
    p_ReadAddr1   = 3'd0;
    p_ReadAddr2   = 3'd0;
    p_WriteAddr   = 3'd0;
    p_EnableWrite = 1'b0;
    p_AluOp       = 1'b0;
    p_DataSel     = DSEL_OUT2;
    p_Done        = 1'b0;

    case (state_q)
      S_IDLE: if (p_Run) state_d = S_FETCH;
      S_FETCH: begin
        p_ReadAddr1 = PC_REG;
        p_MemReq    = 1'b1;
        if (p_MemAck) begin
          ir_d    = p_MemData;
          inc_pc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = ctrl.nop ? S_DONE : S_EXEC;
      S_EXEC: begin
        p_DataSel   = ctrl.data_sel;
        p_WriteAddr = ctrl.write ? rx : 3'd0;
        if (ctrl.mem) begin
          // Address and store data stay on the bank ports until the ack
          p_MemReq    = 1'b1;
          p_MemWe     = ctrl.store;
          p_ReadAddr1 = ctrl.imm ? PC_REG : ry;
          p_ReadAddr2 = ctrl.store ? rx : 3'd0;
          if (p_MemAck) begin
            p_EnableWrite = ctrl.write;
            inc_pc        = ctrl.imm;
            state_d       = S_DONE;
          end
        end else begin
          p_ReadAddr1   = ctrl.alu ? rx : 3'd0;
          p_ReadAddr2   = ry;
          p_AluOp       = ctrl.sub;
          p_EnableWrite = ctrl.cond ? nz_q : ctrl.write;
          if (ctrl.alu) nz_d = ~p_AluZero;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        p_Done  = 1'b1;
        state_d = p_Run ? S_FETCH : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // An explicit write to the PC overrides the auto-increment (jumps)
    p_IncPC = inc_pc && !(p_EnableWrite && (p_WriteAddr == PC_REG));

`ifdef PROC_CTRL_TIMEOUT_EN
    wait_cnt_d = '0;
    if (p_MemReq && !p_MemAck) begin
      if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = S_FAULT;
      else wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    p_Fault = (state_q == S_FAULT);
`else
    p_Fault = 1'b0;
`endif
  end

  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      nz_q       <= 1'b0;
`ifdef PROC_CTRL_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      nz_q       <= nz_d;
`ifdef PROC_CTRL_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm with a register bank, ALU and handshaked
// memory model around it; expected values are hand-computed constants.
module tb_proc_control_fsm;

  logic        p_Clock = 1'b0;
  logic        p_Resetn = 1'b0;
  logic        p_Run = 1'b0;
  logic [15:0] p_MemData;
  logic        p_MemAck;
  logic        p_AluZero;
  logic        p_MemReq, p_MemWe, p_EnableWrite, p_IncPC, p_AluOp, p_Done, p_Fault;
  logic [2:0]  p_ReadAddr1, p_ReadAddr2, p_WriteAddr;
  logic [1:0]  p_DataSel;

  proc_control_fsm dut (
    .p_Clock       (p_Clock),
    .p_Resetn      (p_Resetn),
    .p_Run         (p_Run),
    .p_MemData     (p_MemData),
    .p_MemAck      (p_MemAck),
    .p_AluZero     (p_AluZero),
    .p_MemReq      (p_MemReq),
    .p_MemWe       (p_MemWe),
    .p_ReadAddr1   (p_ReadAddr1),
    .p_ReadAddr2   (p_ReadAddr2),
    .p_WriteAddr   (p_WriteAddr),
    .p_EnableWrite (p_EnableWrite),
    .p_IncPC       (p_IncPC),
    .p_AluOp       (p_AluOp),
    .p_DataSel     (p_DataSel),
    .p_Done        (p_Done),
    .p_Fault       (p_Fault)
  );

  always #5 p_Clock = ~p_Clock;

  // Datapath / memory model
  logic [15:0] regs [8]   = '{default: 16'h0000};
  logic [15:0] mem  [256] = '{default: 16'h0000};
  logic [15:0] dout1, dout2, alu_res, din;
  int          ack_delay = 0;
  int          req_wait = 0;
  int          cyc = 0;
  logic        poke_en = 1'b0, poke_mem = 1'b0;
  logic [7:0]  poke_addr = 8'h00;
  logic [15:0] poke_val = 16'h0000;
  logic [17:0] outs;

  assign dout1     = regs[p_ReadAddr1];
  assign dout2     = regs[p_ReadAddr2];
  assign alu_res   = p_AluOp ? dout1 - dout2 : dout1 + dout2;
  assign p_AluZero = (alu_res == 16'h0000);
  assign p_MemData = mem[dout1[7:0]];
  assign din       = (p_DataSel == 2'b00) ? dout2 : (p_DataSel == 2'b01) ? alu_res : p_MemData;
  assign p_MemAck  = p_MemReq && (req_wait >= ack_delay);
  assign outs = {p_MemReq, p_MemWe, p_ReadAddr1, p_ReadAddr2, p_WriteAddr, p_EnableWrite,
                 p_IncPC, p_AluOp, p_DataSel, p_Done, p_Fault};

  always @(posedge p_Clock) begin
    cyc <= cyc + 1;
    req_wait <= (!p_MemReq || p_MemAck) ? 0 : req_wait + 1;
    if (poke_en) begin
      if (poke_mem) mem[poke_addr] <= poke_val;
      else regs[poke_addr[2:0]] <= poke_val;
    end else begin
      if (p_IncPC) regs[7] <= regs[7] + 16'd1;
      if (p_EnableWrite) regs[p_WriteAddr] <= din;
      if (p_MemReq && p_MemAck && p_MemWe) mem[dout1[7:0]] <= dout2;
    end
  end

  // Request monitor: one record per completed memory handshake
  typedef struct {
    int          len;
    bit          stable;
    bit          we;
    logic [15:0] addr;
  } req_t;
  req_t        reqs[$];
  bit          m_active = 0, m_stable = 0, m_we = 0;
  int          m_len = 0;
  logic [2:0]  m_rd1, m_rd2;
  logic [15:0] m_addr;
  int          jump_cnt = 0;
  logic        jump_inc = 1'b0;

  initial forever begin
    @(negedge p_Clock);
    if (p_MemReq) begin
      if (!m_active) begin
        m_active = 1; m_len = 0; m_stable = 1;
        m_rd1 = p_ReadAddr1; m_rd2 = p_ReadAddr2; m_we = p_MemWe; m_addr = dout1;
      end
      m_len++;
      if (p_ReadAddr1 != m_rd1 || p_ReadAddr2 != m_rd2 || p_MemWe != m_we || dout1 != m_addr)
        m_stable = 0;
      if (p_MemAck) begin
        reqs.push_back('{m_len, m_stable, m_we, m_addr});
        m_active = 0;
      end
    end else begin
      m_active = 0;
    end
    if (p_EnableWrite && p_WriteAddr == 3'd7) begin
      jump_cnt++;
      jump_inc = p_IncPC;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int gaps[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic poke(input bit is_mem, input logic [7:0] addr, input logic [15:0] val);
    @(negedge p_Clock);
    poke_en = 1'b1; poke_mem = is_mem; poke_addr = addr; poke_val = val;
    @(negedge p_Clock);
    poke_en = 1'b0;
  endtask

  // Run n instructions from IDLE; gaps holds cycles between successive Done pulses
  task automatic run_n(input string tag, input int n);
    int seen = 0;
    int last = cyc;
    gaps.delete();
    p_Run = 1'b1;
    for (int b = 0; b < 300 && seen < n; b++) begin
      @(negedge p_Clock);
      if (p_Done) begin
        gaps.push_back(cyc - last);
        last = cyc;
        seen++;
        if (seen == n) p_Run = 1'b0;
      end
    end
    p_Run = 1'b0;
    check({tag, "_done_cnt"}, seen, n);
    @(negedge p_Clock);
  endtask

  function automatic int gap(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  initial begin
    int base, nreq, ndone;

    // Program images
    mem[8'h00] = 16'h2800; mem[8'h01] = 16'h00A5; mem[8'h02] = 16'h0D00;  // mvi R2; mv R3,R2
    mem[8'h20] = 16'h6080; mem[8'h21] = 16'hD000;                         // sub R0,R1; mvnz R4,R0
    mem[8'h22] = 16'h4080; mem[8'h23] = 16'hD000;                         // add R0,R1; mvnz R4,R0
    mem[8'h30] = 16'h9A80; mem[8'h31] = 16'hB880;                         // ld R6,[R5]; st R6,[R1]
    mem[8'h40] = 16'hBEEF;
    mem[8'h38] = 16'h3C00; mem[8'h39] = 16'h0010;                         // mvi R7,0x0010
    mem[8'h10] = 16'hE000;                                                // nop

    repeat (2) @(negedge p_Clock);
    check("rst_outputs_initial", outs, 0);
    p_Resetn = 1'b1;
    repeat (2) @(negedge p_Clock);

    // Async reset in the middle of a stalled fetch
    ack_delay = 100;
    p_Run = 1'b1;
    repeat (3) @(negedge p_Clock);
    check("fetch_req_pending", p_MemReq, 1);
    #2 p_Resetn = 1'b0;
    #1 check("rst_mid_fetch_outputs", outs, 0);
    p_Run = 1'b0;
    @(negedge p_Clock);
    p_Resetn = 1'b1;
    nreq = 0; ndone = 0;
    repeat (5) begin
      @(negedge p_Clock);
      nreq += int'(p_MemReq);
      ndone += int'(p_Done);
    end
    check("idle_no_memreq", nreq, 0);
    check("idle_no_done", ndone, 0);
    check("idle_pc", regs[7], 16'h0000);

    // mvi R2,0x00A5 ; mv R3,R2 with zero-wait ack
    ack_delay = 0;
    run_n("mvi_mv", 2);
    check("mvi_r2", regs[2], 16'h00A5);
    check("mv_r3", regs[3], 16'h00A5);
    check("mvi_mv_pc", regs[7], 16'h0003);
    check("mvi_latency", gap(0), 4);
    check("mv_latency", gap(1), 4);

    // NZ flag: sub to zero blocks mvnz, add to non-zero enables it
    poke(0, 8'd0, 16'd5);
    poke(0, 8'd1, 16'd5);
    poke(0, 8'd4, 16'h1234);
    poke(0, 8'd7, 16'h0020);
    run_n("sub_mvnz", 2);
    check("sub_r0", regs[0], 16'h0000);
    check("mvnz_blocked_r4", regs[4], 16'h1234);
    run_n("add_mvnz", 2);
    check("add_r0", regs[0], 16'h0005);
    check("mvnz_taken_r4", regs[4], 16'h0005);
    check("nz_pc", regs[7], 16'h0024);

    // ld / st with 3-cycle ack delay
    poke(0, 8'd5, 16'h0040);
    poke(0, 8'd1, 16'h0041);
    poke(0, 8'd6, 16'h0000);
    poke(0, 8'd7, 16'h0030);
    ack_delay = 3;
    base = reqs.size();
    run_n("ld_st", 2);
    check("ld_r6", regs[6], 16'hBEEF);
    check("st_mem41", mem[8'h41], 16'hBEEF);
    check("ld_latency", gap(0), 10);
    check("st_latency", gap(1), 10);
    check("ldst_req_count", reqs.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < reqs.size()) begin
        check($sformatf("ldst_req%0d_len", i), reqs[base+i].len, 4);
        check($sformatf("ldst_req%0d_stable", i), reqs[base+i].stable, 1);
        check($sformatf("ldst_req%0d_we", i), reqs[base+i].we, (i == 3) ? 1 : 0);
      end
    end
    if (base + 3 < reqs.size()) begin
      check("ld_addr", reqs[base+1].addr, 16'h0040);
      check("st_addr", reqs[base+3].addr, 16'h0041);
    end

    // mvi R7,0x0010 acts as a jump, then a nop at the target
    ack_delay = 0;
    poke(0, 8'd7, 16'h0038);
    base = reqs.size();
    run_n("jump", 2);
    check("jump_write_seen", jump_cnt, 1);
    check("jump_incpc", jump_inc, 0);
    check("jump_target_fetch", (base + 2 < reqs.size()) ? reqs[base+2].addr : 16'hFFFF, 16'h0010);
    check("jump_pc_after_nop", regs[7], 16'h0011);
    check("nop_latency", gap(1), 3);

`ifdef PROC_CTRL_TIMEOUT_EN
    // Ack never arrives: fault after 15 request cycles, request stays low
    ack_delay = 100000;
    nreq = 0;
    p_Run = 1'b1;
    for (int b = 0; b < 60; b++) begin
      @(negedge p_Clock);
      p_Run = 1'b0;
      if (p_Fault) break;
      nreq += int'(p_MemReq);
    end
    check("timeout_req_cycles", nreq, 15);
    check("timeout_fault", p_Fault, 1);
    nreq = 0;
    repeat (4) begin
      @(negedge p_Clock);
      nreq += int'(p_MemReq);
    end
    check("fault_no_memreq", nreq, 0);
    check("fault_sticky_outs", outs, 18'h00001);
    p_Resetn = 1'b0;
    #1 check("fault_cleared_by_reset", p_Fault, 0);
    @(negedge p_Clock);
    p_Resetn = 1'b1;
`else
    check("fault_tied_low", p_Fault, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
